// File: rtl/edge_period_classifier.sv
// edge_period_classifier: measures rising-edge periods of a pixel bit stream and accumulates clocks per frequency class
// Ports:
//   clock, resetn       system clock, asynchronous active-low reset
//   sample_data         thresholded pixel bit (asynchronous, synchronized here)
//   enable              measurement enable (asynchronous, synchronized here)
//   clear               synchronous active-low clear of accumulators and state
//   f0_value, f1_value  saturating accumulated clocks of periods classified f0 / f1
//   unknown             saturating accumulated clocks of unclassified periods
//   last_period         most recent measured period in clocks
module edge_period_classifier #(
  parameter int FREQUENCY0 = 7500,
  parameter int FREQUENCY1 = 10000,
  parameter int DEVIATION_PERCENT = 10,
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     sample_data,
  input  logic                     enable,
  input  logic                     clear,
  output logic [COUNTER_WIDTH-1:0] f0_value,
  output logic [COUNTER_WIDTH-1:0] f1_value,
  output logic [COUNTER_WIDTH-1:0] unknown,
  output logic [COUNTER_WIDTH-1:0] last_period
);
  localparam int CW = COUNTER_WIDTH;
  localparam int P0 = CLOCK_FREQUENCY / FREQUENCY0;
  localparam int P1 = CLOCK_FREQUENCY / FREQUENCY1;
  localparam int D0 = P0 * DEVIATION_PERCENT / 100;
  localparam int D1 = P1 * DEVIATION_PERCENT / 100;
  localparam logic [CW-1:0] LO0 = CW'(P0 - D0);
  localparam logic [CW-1:0] HI0 = CW'(P0 + D0);
  localparam logic [CW-1:0] LO1 = CW'(P1 - D1);
  localparam logic [CW-1:0] HI1 = CW'(P1 + D1);
  localparam logic [CW-1:0] TIMEOUT = CW'(2 * ((P0 + D0) > (P1 + D1) ? (P0 + D0) : (P1 + D1)));
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  state_t state_q, state_d;
  logic [1:0] smp_q, en_q;
  logic prev_q;
  logic [CW-1:0] cnt_q, cnt_d, f0_q, f0_d, f1_q, f1_d, unk_q, unk_d, last_q, last_d;
  logic rise, en_s, in0, in1;
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CW] ? '1 : s[CW-1:0];
  endfunction
  assign rise = smp_q[1] & ~prev_q;
  assign en_s = en_q[1];
  // f0 is tested first so it wins if the two windows overlap
  assign in0 = cnt_q >= LO0 && cnt_q <= HI0;
  assign in1 = !in0 && cnt_q >= LO1 && cnt_q <= HI1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    f0_d = f0_q;
    f1_d = f1_q;
    unk_d = unk_q;
    last_d = last_q;
    if (!en_s) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM: if (rise) begin
          cnt_d = 1;
          state_d = MEASURE;
        end
        default: if (rise) begin
          last_d = cnt_q;
          cnt_d = 1;
          f0_d = in0 ? sat_add(f0_q, cnt_q) : f0_q;
          f1_d = in1 ? sat_add(f1_q, cnt_q) : f1_q;
          unk_d = (!in0 && !in1) ? sat_add(unk_q, cnt_q) : unk_q;
        end else if (cnt_q == TIMEOUT) state_d = ARM;
        else cnt_d = cnt_q + 1'b1;
      endcase
    end
    if (!clear) begin
      cnt_d = '0;
      f0_d = '0;
      f1_d = '0;
      unk_d = '0;
      last_d = '0;
      state_d = en_s ? ARM : IDLE;
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      smp_q <= '0;
      en_q <= '0;
      prev_q <= 1'b0;
      cnt_q <= '0;
      f0_q <= '0;
      f1_q <= '0;
      unk_q <= '0;
      last_q <= '0;
    end else begin
      state_q <= state_d;
      smp_q <= {smp_q[0], sample_data};
      en_q <= {en_q[0], enable};
      prev_q <= smp_q[1];
      cnt_q <= cnt_d;
      f0_q <= f0_d;
      f1_q <= f1_d;
      unk_q <= unk_d;
      last_q <= last_d;
    end
  end
  assign f0_value = f0_q;
  assign f1_value = f1_q;
  assign unknown = unk_q;
  assign last_period = last_q;
endmodule
